// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states, widths.
package alu_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SHAMT_W = 4;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SUBI = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Combinational single-cycle ALU ops with zero/overflow/illegal flags.
// Shift codes pass src_a through so a zero-amount shift completes here.
module alu_logic_core #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);
  import alu_pkg::*;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   slt_diff;

  assign sum      = a + b;
  assign diff     = a - b;
  // Sign-extended difference gives a signed compare immune to overflow.
  assign slt_diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (op_code)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB, ALU_SUBI: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: result = WIDTH'(slt_diff[WIDTH]);
      ALU_SLL, ALU_SRA: result = a;
      default: illegal = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: handshake FSM around a one-cycle logic core and an
// iterative one-bit-per-cycle shifter.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);
  import alu_pkg::*;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [SHAMT_W-1:0] cnt;
  logic               shift_left;

  logic [WIDTH-1:0]   core_result;
  logic               core_zero;
  logic               core_ovf;
  logic               core_illegal;
  logic [WIDTH-1:0]   shift_next;
  logic [SHAMT_W-1:0] shamt;

  alu_logic_core #(.WIDTH(WIDTH)) u_core (
    .op_code (op_code),
    .a       (src_a),
    .b       (src_b),
    .result  (core_result),
    .zero    (core_zero),
    .ovf     (core_ovf),
    .illegal (core_illegal)
  );

  assign shamt      = src_b[SHAMT_W-1:0];
  assign shift_next = shift_left ? {shreg[WIDTH-2:0], 1'b0}
                                 : {shreg[WIDTH-1], shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_ready   <= 1'b1;
      res_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
      illegal    <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            if (is_shift(op_code) && (shamt != '0)) begin
              shreg      <= src_a;
              cnt        <= shamt;
              shift_left <= (op_code == ALU_SLL);
              state      <= ST_SHIFT;
            end else begin
              result    <= core_result;
              zero      <= core_zero;
              ovf       <= core_ovf;
              illegal   <= core_illegal;
              res_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - SHAMT_W'(1);
          // Last step: publish the shifted value directly.
          if (cnt == SHAMT_W'(1)) begin
            result    <= shift_next;
            zero      <= (shift_next == '0);
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit: handshakes, latency, flags,
// backpressure and mid-shift reset.
module tb_alu_exec_unit;

  typedef struct {
    string       tag;
    logic [15:0] r;
    logic        z;
    logic        o;
    logic        i;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .src_a     (src_a),
    .src_b     (src_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op, hold it until accepted, then scramble the inputs.
  task automatic send(input string tag, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] r, input logic z,
                      input logic o, input logic i, input int lat, input bit push);
    exp_t e;
    int   w;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    w = 0;
    while (op_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_accept"}, 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 4'($urandom);
    src_a    = 16'($urandom);
    src_b    = 16'($urandom);
    e.tag = tag; e.r = r; e.z = z; e.o = o; e.i = i; e.lat = lat;
    if (push) sb.push_back(e);
  endtask

  // Wait (bounded) for the result, then compare against the scoreboard head.
  task automatic collect();
    exp_t e;
    int   edges = 0;
    bit   busy_ok = 1'b1;
    while (res_valid !== 1'b1 && edges < 40) begin
      if (op_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    chk("res_valid_seen", 32'(res_valid), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_busy"},    32'(busy_ok),   32'd1);
    chk({e.tag, "_latency"}, 32'(edges),     32'(e.lat));
    chk({e.tag, "_result"},  32'(result),    32'(e.r));
    chk({e.tag, "_zero"},    32'(zero),      32'(e.z));
    chk({e.tag, "_ovf"},     32'(ovf),       32'(e.o));
    chk({e.tag, "_illegal"}, 32'(illegal),   32'(e.i));
    chk({e.tag, "_ready_lo"}, 32'(op_ready), 32'd0);
    if (res_ready) begin
      @(posedge clk);
      #1;
      chk({e.tag, "_valid_drop"}, 32'(res_valid), 32'd0);
      chk({e.tag, "_ready_back"}, 32'(op_ready),  32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stale;
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_code   = 4'h0;
    src_a     = 16'h0;
    src_b     = 16'h0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready",  32'(op_ready),  32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_flags",     32'({zero, ovf, illegal}), 32'd0);
    reset = 1'b0;

    send("add_ovf", 4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    collect();
    send("sub_beq", 4'b1100, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    collect();
    send("subi_ovf", 4'b1101, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    collect();
    send("slt_neg", 4'b0001, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    collect();
    send("sra_3", 4'b0111, 16'h8000, 16'h0003, 16'hF000, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    collect();
    send("sra_hi_ign", 4'b0111, 16'h8000, 16'h00F2, 16'hE000, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    collect();
    send("sll_15", 4'b0110, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 15, 1'b1);
    collect();
    send("sll_0", 4'b0110, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    collect();
    send("sll_out", 4'b0110, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    collect();

    // Backpressure: result must hold for 5 cycles with the unit busy.
    res_ready = 1'b0;
    send("xor_bp", 4'b0011, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    collect();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid",  32'(res_valid), 32'd1);
      chk("bp_result", 32'(result),    32'h0000FFFF);
      chk("bp_ready",  32'(op_ready),  32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop",       32'(res_valid), 32'd0);
    chk("bp_ready_back", 32'(op_ready),  32'd1);

    // Reset lands at edge T+4 of a 10-step SRA.
    send("sra_abort", 4'b0111, 16'h8000, 16'h000A, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid",  32'(res_valid), 32'd0);
    chk("abort_ready",  32'(op_ready),  32'd1);
    chk("abort_result", 32'(result),    32'd0);
    chk("abort_flags",  32'({zero, ovf, illegal}), 32'd0);
    reset = 1'b0;
    stale = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (res_valid !== 1'b0) stale = 1'b1;
    end
    chk("abort_no_stale", 32'(stale), 32'd0);

    send("illegal", 4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    collect();
    send("and_after", 4'b0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    collect();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU datapath that consumes the 4-bit ALU operation code produced by the ALU control decode. It returns a result together with zero/overflow flags.
- Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle.
- Operands and op code enter on a valid/ready handshake; the result leaves on a second valid/ready handshake to writeback and branch logic.

Parameters:
- WIDTH, 16, datapath width in bits.
- SHAMT_W, 4, shift-amount width, taken from src_b[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  op_code, src_a and src_b are valid.
- op_ready  output  1  unit can accept an operation.
- op_code  input  4  ALU operation code from ALU control.
- src_a  input  WIDTH  operand A (rs).
- src_b  input  WIDTH  operand B (rt or sign-extended immediate).
- res_valid  output  1  result, zero, ovf and illegal are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result equals 0; used for BEQ.
- ovf  output  1  signed overflow; ADD/SUB only, 0 otherwise.
- illegal  output  1  op_code is not in the supported set.

Behaviour:
- Op codes:
  - 0000 AND
  - 0010 OR
  - 0011 XOR
  - 0100 ADD (also LW/SW address and ADDI)
  - 1100 SUB (also BEQ)
  - 1101 SUBI (same datapath as SUB)
  - 0001 SLT signed, result = {0..0, a<b}
  - 0110 SLL by src_b[3:0]
  - 0111 SRA by src_b[3:0]
- Any other code: result 0, zero 1, ovf 0, illegal 1, with 1-cycle latency.
- Reset: state IDLE. op_ready=1; res_valid, result, zero, ovf and illegal = 0; shift counter 0.
- Reset asserted mid-shift or while DONE aborts the operation. Nothing is emitted afterwards.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready, latch op_code, src_a, src_b.
  - Single-cycle op (or shift with amount 0): compute result, go to DONE.
  - Shift with amount n>0: load shift register with src_a and counter with n, go to SHIFT.
- SHIFT:
  - op_ready=0.
  - Each cycle: SLL shifts left by 1 inserting 0; SRA shifts right by 1 replicating bit WIDTH-1. Counter decrements by 1.
  - When counter reaches 1, the final step is performed, then go to DONE.
- DONE:
  - res_valid=1; outputs held stable while res_ready=0.
  - On res_ready, res_valid falls the next cycle and state returns to IDLE.
  - No new op is accepted in the DONE cycle.
- Latency, with acceptance at edge T:
  - single-cycle ops: res_valid from cycle T+1;
  - shifts: res_valid from cycle T+1+n.
  - Minimum issue interval is 2 cycles.
- Arithmetic: WIDTH-bit two's complement, wrap-around with no saturation.
  - ovf for ADD = (a[15]==b[15]) && (r[15]!=a[15]).
  - ovf for SUB/SUBI = (a[15]!=b[15]) && (r[15]!=a[15]).
  - SLT compares signed and ignores overflow by using the sign of the full 17-bit difference.
- zero is computed from the final result for every op, including shifts and SLT.
- src_b[15:4] is ignored for shifts. Operand changes on the input after acceptance have no effect.
- op_valid while op_ready=0: ignored. The producer must hold it until accepted.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams (ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SUBI, ALU_SLT, ALU_SLL, ALU_SRA);
  - FSM state encoding;
  - WIDTH default.
- One sub-module, alu_logic_core: purely combinational single-cycle ops plus zero/ovf/illegal generation.
- The FSM, shift register, counter and handshake live in alu_exec_unit.

Test Plan:
- ADD 0x7FFF+0x0001, res_ready=1 -> res_valid at T+1, result 0x8000, ovf 1, zero 0, illegal 0.
- SUB 0x1234-0x1234 (BEQ case) -> result 0x0000, zero 1, ovf 0. SLT 0xFFFF vs 0x0001 -> result 0x0001.
- SRA 0x8000 by src_b=0x0003 -> op_ready low 3 cycles, res_valid at T+4, result 0xF000. SLL 0x0001 by 15 -> result 0x8000 at T+16. SLL by 0 -> result = src_a at T+1.
- Backpressure: XOR 0xAAAA^0x5555 with res_ready=0 for 5 cycles -> result 0xFFFF held stable, op_ready=0 throughout; res_valid drops the cycle after res_ready=1.
- Reset asserted during SRA by 10 at cycle T+4 -> next cycle IDLE, res_valid 0, all outputs 0, op_ready 1; no stale result ever appears.
- Illegal op_code 1111 -> result 0, zero 1, illegal 1 at T+1; a following AND 0xF0F0&0x0FF0 -> 0x00F0 with illegal 0.
